// File: rtl/score_display_pkg.sv
// score_display_pkg
// Shared definitions for the score display scanner:
//   - active-low 7-segment codes (bit6=A .. bit0=G) for digits 0-9 and blank
//   - converter FSM state type
//   - max_decimal(): largest value representable in N decimal digits
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } conv_state_t;

  // 10^n - 1, the saturation bound for an n-digit display.
  function automatic logic [63:0] max_decimal(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// seven_seg_encoder
// Combinational BCD digit to active-low 7-segment pattern.
// Ports:
//   bcd   in  4  BCD digit; codes 10-15 render as blank
//   blank in  1  force all segments off
//   seg   out 7  active-low segments, bit6=A .. bit0=G
module seven_seg_encoder
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_scanner.sv
// score_display_scanner
// Converts a binary score to BCD (sequential shift-add-3), commits it
// atomically to a display register and scans it onto a time-multiplexed
// active-low 7-segment display.
// Ports:
//   clock    in  1           rising-edge clock
//   resetn   in  1           synchronous active-low reset
//   load     in  1           capture value (dropped while converting)
//   value    in  BIN_WIDTH   unsigned binary score
//   busy     out 1           conversion in progress
//   overflow out 1           last committed value exceeded 10^NUM_DIGITS-1
//   seg      out 7           active-low segments, bit6=A .. bit0=G
//   an       out NUM_DIGITS  active-low digit enables, an[0] = LSD
module score_display_scanner
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 5,
  parameter int BIN_WIDTH     = 17,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [BIN_WIDTH-1:0]  value,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = max_decimal(NUM_DIGITS);

  conv_state_t          state;
  logic [BIN_WIDTH-1:0] bin;
  logic [BCD_W-1:0]     bcd, bcd_adj, disp;
  logic                 pend_ovf;
  logic [CNT_W-1:0]     cnt;

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [3:0]            cur_nib;
  logic                  cur_blank, upper_zero;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            seg_enc;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                  : bcd[4*i +: 4];
  end

  // Converter FSM. busy tracks the CONVERT phase one cycle behind the
  // state so that it is high exactly BIN_WIDTH cycles and drops on the
  // same edge the display register is written.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      disp     <= '0;
      bin      <= '0;
      bcd      <= '0;
      pend_ovf <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin      <= value;
            bcd      <= '0;
            pend_ovf <= (64'(value) > MAX_VAL);
            cnt      <= '0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          busy <= 1'b1;
          // Carries out of the top nibble are dropped; saturation covers them.
          bcd  <= {bcd_adj[BCD_W-2:0], bin[BIN_WIDTH-1]};
          bin  <= bin << 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          disp     <= pend_ovf ? {NUM_DIGITS{4'h9}} : bcd;
          overflow <= pend_ovf;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit mux, anode pattern and leading-zero detection for the current slot.
  // upper_zero accumulates from the top digit down, so at digit i it means
  // "this digit and all above are zero".
  always_comb begin
    cur_nib    = '0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    an_sel     = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == digit_idx) begin
        cur_nib   = disp[4*i +: 4];
        an_sel[i] = 1'b0;
        cur_blank = (BLANK_LEADING != 0) && (i != 0) && upper_zero;
      end
    end
  end

  seven_seg_encoder u_enc (
    .bcd   (cur_nib),
    .blank (cur_blank),
    .seg   (seg_enc)
  );

  // Scanner with registered pins. On the terminal-count edge the anodes are
  // all driven off for one cycle while digit_idx moves to the next digit.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      seg       <= SEG_0;
      an        <= ~NUM_DIGITS'(1);
    end else begin
      seg <= seg_enc;
      if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
        div_cnt   <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        an        <= '1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        an      <= an_sel;
      end
    end
  end

endmodule

// File: tb/tb_score_display_scanner.sv
module tb_score_display_scanner;

  localparam int ND = 5;
  localparam int BW = 17;
  localparam int RD = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          load = 1'b0;
  logic [BW-1:0] value = '0;

  logic          busy_a, ovf_a, busy_b, ovf_b;
  logic [6:0]    seg_a, seg_b;
  logic [ND-1:0] an_a, an_b;

  always #5 clock = ~clock;

  // dut_a blanks leading zeros, dut_b does not; both see identical stimulus.
  score_display_scanner #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .BLANK_LEADING(1)) dut_a (
    .clock(clock), .resetn(resetn), .load(load), .value(value),
    .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));

  score_display_scanner #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .BLANK_LEADING(0)) dut_b (
    .clock(clock), .resetn(resetn), .load(load), .value(value),
    .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b));

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  logic [6:0] obs_seg [2][ND];
  int         obs_blank [2];
  int         obs_bad [2];

  // Reference: decimal digit i of the saturated score, blanked when it and
  // everything above it is zero (score < 10^i).
  function automatic logic [6:0] exp_seg(input bit bl, input int v, input int i);
    int sat, p;
    sat = (v > 99999) ? 99999 : v;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (bl && i > 0 && sat < p) return 7'b1111111;
    return seg_tbl[(sat / p) % 10];
  endfunction

  task automatic do_load(input int v);
    value = BW'(v);
    load  = 1'b1;
    @(negedge clock);
    load  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clock);
    while (busy_a === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_done timeout busy still %b after %0d cycles", busy_a, n);
    end
  endtask

  // Observe two full scan rounds, recording per-slot segments, blank-cycle
  // count and any ordering or anti-ghost violations.
  task automatic capture_scan();
    int last_k [2];
    bit prev_blank [2];
    logic [ND-1:0] a;
    int k, nz;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ND; i++) obs_seg[d][i] = 'x;
      obs_blank[d] = 0; obs_bad[d] = 0; last_k[d] = -1; prev_blank[d] = 1'b0;
    end
    repeat (2 * ND * RD) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        a = (d == 0) ? an_a : an_b;
        k = -1; nz = 0;
        for (int i = 0; i < ND; i++) if (a[i] === 1'b0) begin k = i; nz++; end
        if (nz == 0) begin
          obs_blank[d]++;
          prev_blank[d] = 1'b1;
        end else if (nz > 1) begin
          obs_bad[d]++;
        end else begin
          if (last_k[d] >= 0 && ((prev_blank[d] != (k != last_k[d])) ||
              (k != last_k[d] && k != (last_k[d] + 1) % ND)))
            obs_bad[d]++;
          obs_seg[d][k] = (d == 0) ? seg_a : seg_b;
          last_k[d] = k;
          prev_blank[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (seg_a !== 7'b0000001 || an_a !== 5'b11110) begin
      errors++; $display("FAIL reset_pins got seg %b an %b exp 0000001 11110", seg_a, an_a);
    end
    checks++;
    if (busy_a !== 1'b0 || ovf_a !== 1'b0 || busy_b !== 1'b0 || ovf_b !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy %b ovf %b exp 0 0", busy_a, ovf_a);
    end
  endtask

  task automatic test_basic();
    int v;
    v = 12345;
    do_load(v);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_t got %b exp 0", busy_a); end
    for (int c = 0; c < BW; c++) begin
      @(negedge clock);
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy_hi cycle %0d got %b exp 1", c, busy_a); end
    end
    @(negedge clock);
    checks++;
    if (busy_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL basic_busy_lo got busy %b ovf %b exp 0 0", busy_a, ovf_a);
    end
    capture_scan();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (obs_seg[d][i] !== exp_seg(d == 0, v, i)) begin
          errors++; $display("FAIL basic_slot dut%0d slot%0d got %b exp %b", d, i, obs_seg[d][i], exp_seg(d == 0, v, i));
        end
      end
      checks++;
      if (obs_blank[d] !== 2 * ND || obs_bad[d] !== 0) begin
        errors++; $display("FAIL basic_scan dut%0d blanks %0d exp %0d bad %0d exp 0", d, obs_blank[d], 2 * ND, obs_bad[d]);
      end
    end
  endtask

  task automatic test_blanking();
    int v;
    v = 7;
    do_load(v);
    wait_done();
    capture_scan();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (obs_seg[d][i] !== exp_seg(d == 0, v, i)) begin
          errors++; $display("FAIL blank_slot dut%0d slot%0d got %b exp %b", d, i, obs_seg[d][i], exp_seg(d == 0, v, i));
        end
      end
      checks++;
      if (obs_blank[d] !== 2 * ND || obs_bad[d] !== 0) begin
        errors++; $display("FAIL blank_scan dut%0d blanks %0d exp %0d bad %0d exp 0", d, obs_blank[d], 2 * ND, obs_bad[d]);
      end
    end
  endtask

  task automatic test_saturation();
    int vals [2] = '{131071, 0};
    foreach (vals[n]) begin
      do_load(vals[n]);
      wait_done();
      checks++;
      if (ovf_a !== (vals[n] > 99999) || ovf_b !== (vals[n] > 99999)) begin
        errors++; $display("FAIL sat_ovf value %0d got %b exp %b", vals[n], ovf_a, vals[n] > 99999);
      end
      capture_scan();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < ND; i++) begin
          checks++;
          if (obs_seg[d][i] !== exp_seg(d == 0, vals[n], i)) begin
            errors++; $display("FAIL sat_slot value %0d dut%0d slot%0d got %b exp %b", vals[n], d, i, obs_seg[d][i], exp_seg(d == 0, vals[n], i));
          end
        end
      end
    end
  endtask

  task automatic test_load_while_busy();
    do_load(99999);
    repeat (4) @(negedge clock);
    do_load(500);
    wait_done();
    capture_scan();
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (obs_seg[0][i] !== exp_seg(1, 99999, i)) begin
        errors++; $display("FAIL busy_drop slot%0d got %b exp %b", i, obs_seg[0][i], exp_seg(1, 99999, i));
      end
    end
    // A load in the first cycle busy reads low must be taken.
    do_load(12);
    wait_done();
    do_load(500);
    @(negedge clock);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_accept got busy %b exp 1", busy_a); end
    wait_done();
    capture_scan();
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (obs_seg[0][i] !== exp_seg(1, 500, i)) begin
        errors++; $display("FAIL accept_slot slot%0d got %b exp %b", i, obs_seg[0][i], exp_seg(1, 500, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_load(131071);
    wait_done();
    do_load(4321);
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if (busy_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got busy %b ovf %b exp 0 0", busy_a, ovf_a);
    end
    checks++;
    if (seg_a !== 7'b0000001 || an_a !== 5'b11110) begin
      errors++; $display("FAIL rst_mid_pins got seg %b an %b exp 0000001 11110", seg_a, an_a);
    end
    resetn = 1'b1;
    repeat (BW + 4) @(negedge clock);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_abort got busy %b exp 0", busy_a); end
    capture_scan();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (obs_seg[d][i] !== exp_seg(d == 0, 0, i)) begin
          errors++; $display("FAIL rst_mid_slot dut%0d slot%0d got %b exp %b", d, i, obs_seg[d][i], exp_seg(d == 0, 0, i));
        end
      end
      checks++;
      if (obs_blank[d] !== 2 * ND || obs_bad[d] !== 0) begin
        errors++; $display("FAIL rst_mid_scan dut%0d blanks %0d exp %0d bad %0d exp 0", d, obs_blank[d], 2 * ND, obs_bad[d]);
      end
    end
  endtask

  task automatic test_random();
    int v;
    repeat (10) begin
      v = int'($urandom_range(0, 131071));
      do_load(v);
      wait_done();
      checks++;
      if (ovf_a !== (v > 99999)) begin
        errors++; $display("FAIL rand_ovf value %0d got %b exp %b", v, ovf_a, v > 99999);
      end
      capture_scan();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < ND; i++) begin
          checks++;
          if (obs_seg[d][i] !== exp_seg(d == 0, v, i)) begin
            errors++; $display("FAIL rand_slot value %0d dut%0d slot%0d got %b exp %b", v, d, i, obs_seg[d][i], exp_seg(d == 0, v, i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_saturation();
    test_load_while_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
